// File: rtl/ram_fifo_arbiter.sv
// Round-robin arbiter draining fixed BURST_LEN bursts from N FWFT ToRAM FIFOs onto one
// valid/ready write-data port. Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module ram_fifo_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned BURST_LEN = 8,
  parameter int          DELAY     = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N-1:0]             fifo_empty,
  input  logic [N-1:0]             fifo_almost_empty,
  input  logic [N*WIDTH-1:0]       fifo_dout,
  output logic [N-1:0]             fifo_rden,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N)-1:0]     out_id,
  output logic                     out_last,
  output logic                     busy
);

  localparam int unsigned IdW   = $clog2(N);
  localparam int unsigned BeatW = $clog2(BURST_LEN);

  // DELAY is kept for interface compatibility only; the logic is delay-free.
  if (N < 2 || N > 8 || BURST_LEN < 2 || BURST_LEN > 64 ||
      (BURST_LEN & (BURST_LEN - 1)) != 0 || DELAY < 0) begin : gen_param_check
    $error("ram_fifo_arbiter: illegal parameter combination");
  end

  typedef enum logic {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [BeatW-1:0] beat_q, beat_d;
`ifndef ARB_FIXED_PRIORITY_EN
  logic [IdW-1:0]   ptr_q, ptr_d;
`endif

  logic [N-1:0]   eligible;
  logic           hit;
  logic [IdW-1:0] pick;
  logic [IdW-1:0] cand;
  logic           handshake;

  assign eligible  = ~fifo_empty & ~fifo_almost_empty;
  assign handshake = out_valid && out_ready;

  // First eligible requester in search order.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      cand = IdW'(i);
`else
      cand = IdW'((32'(ptr_q) + 1 + i) % N);
`endif
      if (!hit && eligible[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
`ifndef ARB_FIXED_PRIORITY_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StBurst;
          grant_d = pick;
          beat_d  = '0;
`ifndef ARB_FIXED_PRIORITY_EN
          ptr_d   = pick;
`endif
        end
      end
      StBurst: begin
        if (handshake) begin
          beat_d = beat_q + 1'b1;
          if (out_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      grant_q <= '0;
      beat_q  <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_q   <= IdW'(N - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    out_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q == IdW'(i)) out_data = fifo_dout[i*WIDTH +: WIDTH];
    end
    out_id    = grant_q;
    busy      = (state_q == StBurst);
    out_valid = busy && !fifo_empty[grant_q];
    out_last  = out_valid && (beat_q == BeatW'(BURST_LEN - 1));
    fifo_rden = '0;
    // Pop is combinational so the FWFT head advances in the same cycle as the handshake.
    fifo_rden[grant_q] = handshake;
  end

endmodule

// File: tb/tb_ram_fifo_arbiter.sv
// Directed bench for ram_fifo_arbiter: N=4, BURST_LEN=8, 16-bit words, behavioural FWFT FIFOs.
module tb_ram_fifo_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned BL = 8;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [N-1:0]   fifo_empty;
  logic [N-1:0]   fifo_almost_empty;
  logic [N*W-1:0] fifo_dout;
  logic [N-1:0]   fifo_rden;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_last;
  logic           busy;

  always #5 CLK = ~CLK;

  ram_fifo_arbiter #(
    .N(N), .WIDTH(W), .BURST_LEN(BL), .DELAY(1)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_dout(fifo_dout), .fifo_rden(fifo_rden),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .busy(busy)
  );

  logic [W-1:0] mem [N][64];
  int           head [N];
  int           tail [N];
  logic [N-1:0] ae_low;
  int           n_chk  = 0;
  int           n_fail = 0;

`ifdef ARB_FIXED_PRIORITY_EN
  int order [6] = '{0, 0, 1, 1, 2, 2};
`else
  int order [6] = '{0, 1, 2, 3, 0, 1};
`endif

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      fifo_empty[i]        = (head[i] == tail[i]);
      fifo_almost_empty[i] = ((tail[i] - head[i]) < int'(BL)) && !ae_low[i];
      fifo_dout[i*W +: W]  = fifo_empty[i] ? 16'hdead : mem[i][head[i] % 64];
    end
  endtask

  task automatic push(input int id, input int val);
    mem[id][tail[id] % 64] = W'(val);
    tail[id]++;
  endtask

  task automatic cyc();
    logic [N-1:0] r;
    r = fifo_rden;
    @(posedge CLK);
    #1;
    for (int i = 0; i < int'(N); i++) if (r[i]) head[i]++;
    drive();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input int id, input int data, input int last);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_id"}, 32'(out_id), id);
    chk({tag, "_data"}, 32'(out_data), data);
    chk({tag, "_last"}, 32'(out_last), last);
    chk({tag, "_rden"}, 32'(fifo_rden), 32'(1) << id);
  endtask

  initial begin
    int wc [N];
    int g;
    int pulses;
    RESET     = 1'b1;
    out_ready = 1'b1;
    ae_low    = '0;
    for (int i = 0; i < int'(N); i++) begin
      head[i] = 0;
      tail[i] = 0;
      wc[i]   = 0;
      for (int k = 0; k < 16; k++) push(i, (i << 8) | k);
    end
    drive();
    #1;

    // Reset held three cycles with every FIFO eligible
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_rden", 32'(fifo_rden), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_id", 32'(out_id), 0);
    end
    RESET = 1'b0;
    #1;

    // Continuous eligibility: 8 beats + 1 bubble per grant
    for (int s = 0; s < 6; s++) begin
      g = order[s];
      chk("rr_idle_busy", 32'(busy), 0);
      chk("rr_idle_valid", 32'(out_valid), 0);
      cyc();
      for (int b = 0; b < int'(BL); b++) begin
        beat($sformatf("rr%0d_b%0d", s, b), g, (g << 8) | (wc[g] + b), (b == 7) ? 1 : 0);
        cyc();
      end
      wc[g] += 8;
    end
    for (int i = 0; i < int'(N); i++) head[i] = tail[i];
    drive();
    #1;
    chk("drain_busy0", 32'(busy), 0);
    cyc();
    chk("drain_busy1", 32'(busy), 0);
    chk("drain_valid", 32'(out_valid), 0);

    // Single requester on FIFO 2
    for (int k = 0; k < 8; k++) push(2, 'h10 + k);
    drive();
    #1;
    chk("single_idle_busy", 32'(busy), 0);
    cyc();
    for (int b = 0; b < 8; b++) begin
      beat($sformatf("single_b%0d", b), 2, 'h10 + b, (b == 7) ? 1 : 0);
      cyc();
    end
    chk("single_gap_busy", 32'(busy), 0);
    chk("single_gap_valid", 32'(out_valid), 0);
    chk("single_gap_rden", 32'(fifo_rden), 0);
    chk("single_gap_last", 32'(out_last), 0);
    chk("single_gap_id", 32'(out_id), 2);

    // Backpressure: ready alternates 0,1 over 16 cycles
    for (int k = 0; k < 8; k++) push(3, 'h30 + k);
    drive();
    #1;
    chk("bp_idle_busy", 32'(busy), 0);
    cyc();
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      out_ready = (k % 2 == 1);
      #1;
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("bp%0d_id", k), 32'(out_id), 3);
      chk($sformatf("bp%0d_data", k), 32'(out_data), 'h30 + k / 2);
      chk($sformatf("bp%0d_last", k), 32'(out_last), (k / 2 == 7) ? 1 : 0);
      chk($sformatf("bp%0d_rden", k), 32'(fifo_rden), (k % 2 == 1) ? 8 : 0);
      if (fifo_rden[3]) pulses++;
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_pulses", 32'(pulses), 8);
    chk("bp_done_busy", 32'(busy), 0);

    // FIFO 1 starves after beat 3 while FIFO 0 waits
    ae_low[1] = 1'b1;
    for (int k = 0; k < 4; k++) push(1, 'h40 + k);
    drive();
    #1;
    chk("starve_idle_busy", 32'(busy), 0);
    cyc();
    ae_low[1] = 1'b0;
    for (int k = 0; k < 8; k++) push(0, 'h50 + k);
    drive();
    #1;
    for (int b = 0; b < 4; b++) begin
      beat($sformatf("starve_b%0d", b), 1, 'h40 + b, 0);
      cyc();
    end
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("starve_gap%0d_valid", c), 32'(out_valid), 0);
      chk($sformatf("starve_gap%0d_busy", c), 32'(busy), 1);
      chk($sformatf("starve_gap%0d_id", c), 32'(out_id), 1);
      chk($sformatf("starve_gap%0d_rden", c), 32'(fifo_rden), 0);
      cyc();
    end
    for (int k = 4; k < 8; k++) push(1, 'h40 + k);
    drive();
    #1;
    for (int b = 4; b < 8; b++) begin
      beat($sformatf("starve_b%0d", b), 1, 'h40 + b, (b == 7) ? 1 : 0);
      cyc();
    end
    chk("starve_bubble_busy", 32'(busy), 0);
    cyc();
    for (int b = 0; b < 8; b++) begin
      beat($sformatf("after_b%0d", b), 0, 'h50 + b, (b == 7) ? 1 : 0);
      cyc();
    end
    chk("after_bubble_busy", 32'(busy), 0);

    // Reset at beat 4 of a grant to id 3
    for (int k = 0; k < 8; k++) push(3, 'h60 + k);
    drive();
    #1;
    chk("mrst_idle_busy", 32'(busy), 0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      beat($sformatf("mrst_b%0d", b), 3, 'h60 + b, 0);
      cyc();
    end
    chk("mrst_b4_data", 32'(out_data), 'h64);
    RESET = 1'b1;
    #1;
    cyc();
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_rden", 32'(fifo_rden), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_id", 32'(out_id), 0);
    for (int k = 0; k < 8; k++) begin
      push(0, 'h70 + k);
      push(1, 'h80 + k);
    end
    drive();
    #1;
    cyc();
    chk("mrst_hold_busy", 32'(busy), 0);
    chk("mrst_hold_rden", 32'(fifo_rden), 0);
    RESET = 1'b0;
    #1;
    chk("mrst_rel_busy", 32'(busy), 0);
    cyc();
    beat("mrst_regrant", 0, 'h70, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
